taxi_stats_counter: RTL
=======================

# taxi_stats_counter

Statistics counter bank downstream of the statistics collector. Consumes the AXI stream of per-ID increment words (tdata = increment, tid = statistic ID), accumulates each into a wide per-ID counter held in on-chip RAM, and serves a simple register-style read port with optional clear-on-read. String words (tuser = 1) are accepted and discarded.

## Interface
- CNT_W, 32: counter width in bits; must be ≥ s_axis_stat.DATA_W.
- SAT_EN, 1'b0: 1 = saturate at all-ones; 0 = wrap modulo 2^CNT_W.
- CLR_ON_RD, 1'b0: 1 = a read atomically zeroes the counter it returns.
- Derived: ID_W = s_axis_stat.ID_W; INC_W = s_axis_stat.DATA_W; DEPTH = 2^ID_W.
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- s_axis_stat  taxi_axis_if.snk  –  tdata = increment, tid = counter index, tuser = string-word flag. tlast, tkeep, tstrb and tdest are ignored.
- rd_req  input  1  read request, held until accepted.
- rd_addr  input  ID_W  counter index to read.
- rd_ack  output  1  request accepted this cycle.
- rd_data  output  CNT_W  counter value.
- rd_valid  output  1  one-cycle strobe; rd_data valid.
- init_done  output  1  counter RAM cleared; block operational.

## Operation
- States: INIT and RUN.
  - Reset enters INIT with sweep index 0.
  - INIT writes 0 to one RAM entry per cycle, DEPTH cycles total, then enters RUN and sets init_done.
  - In INIT, tready = 0 and rd_ack = 0.
- Arbitration in RUN: the read port has priority.
  - rd_ack = rd_req.
  - s_axis_stat.tready = !rd_req.
  - Exactly one operation (read or update) enters the pipeline per cycle.
- Update, accepted when tvalid && tready:
  - tuser = 1: the word is consumed and discarded, with no RAM access.
  - tuser = 0: counter[tid] += zero-extended tdata.
  - SAT_EN = 1: if the sum exceeds 2^CNT_W-1, write all-ones.
  - SAT_EN = 0: keep the low CNT_W bits.
- Read: returns counter[rd_addr] as of the cycle the request was accepted. That value includes every update accepted in earlier cycles.
  - CLR_ON_RD = 1: write 0 to the entry in the same pipeline slot.
- Pipeline: 3-stage read-modify-write.
  - S0: accept the operation and issue the RAM read.
  - S1: RAM data registered.
  - S2: compute, write back and drive rd_data.
- Hazards: the pipeline accepts an update or read every cycle with no stalls.
  - When the S1 address matches the address being written in S2, the S2 write value is forwarded into S1 in place of stale RAM data.
  - The same applies when a write from the previous cycle is not yet visible.
- Zero-value increments still perform the RMW, so the result is unchanged.

## Timing
- Reset values: tready = 0, rd_ack = 0, rd_valid = 0, rd_data = 0, init_done = 0.
- Reset mid-operation: pipeline contents are discarded; INIT restarts from index 0.
- Init latency: init_done rises DEPTH+1 cycles after rst_n is sampled high.
- Read latency: rd_valid is asserted 2 cycles after the rd_ack cycle (accept at cycle T, data at T+2). rd_data holds its value until the next rd_valid.
- Update-to-read visibility: an update accepted at cycle T is reflected in a read accepted at T+1 or later, via forwarding.
- Back-to-back updates to the same tid on consecutive cycles must accumulate exactly; no increment is lost.
- Sustained rd_req starves the stream. The upstream collector tolerates stalls by holding tvalid, so this is acceptable.

## Structure
- Shared package taxi_stats_pkg holds:
  - the state enum (STATE_INIT, STATE_RUN);
  - the op-type enum for pipeline slots (OP_NONE, OP_UPD, OP_RD).
  - The upstream collector is unchanged by this package.
- Sub-module taxi_stats_ram: simple dual-port RAM, DEPTH × CNT_W, one registered read port and one write port, ram_style distributed/block selectable.
- Forwarding, saturation and arbitration stay in the top module.

## Test plan
- Reset and init, ID_W = 4: init_done rises 17 cycles after rst_n goes high. Reading all 16 entries returns 0. tready stays 0 before init_done.
- Single update: tid = 3, tdata = 0x05, then read addr 3 → rd_data = 5, rd_valid two cycles after rd_ack.
- Hazard: tid = 7 with tdata = 1, 2, 3 on three consecutive cycles, then read addr 7 on the next cycle → 6.
- Saturation, CNT_W = 8, INC_W = 8:
  - SAT_EN = 1: tid 0 += 0xF0 then += 0x20 → 0xFF.
  - SAT_EN = 0: the same sequence → 0x10.
- Clear-on-read, CLR_ON_RD = 1: tid 2 += 9; read → 9; read again → 0. An update of +4 accepted the cycle after the first read returns 4 on the next read.
- Arbitration, strings and reset:
  - rd_req held for 3 cycles while tvalid is high → tready is low for those 3 cycles and no update is lost.
  - A tuser = 1 word with tid 1 leaves counter 1 unchanged.
  - rst_n asserted mid-stream → all counters read 0 after re-init.

Source files
------------

// File: rtl/taxi_stats_pkg.sv
// Shared types for the statistics counter bank: block state and pipeline slot contents.
package taxi_stats_pkg;

    // Block-level state: clearing the counter RAM, or serving traffic
    typedef enum logic {
        STATE_INIT,
        STATE_RUN
    } state_t;

    // What occupies a read-modify-write pipeline slot
    typedef enum logic [1:0] {
        OP_NONE,
        OP_UPD,
        OP_RD
    } op_t;

endpackage

// File: rtl/taxi_axis_if.sv
// AXI stream bundle carrying per-ID increment words from the statistics collector.
interface taxi_axis_if #(
    parameter int DATA_W = 8,
    parameter int KEEP_W = (DATA_W + 7) / 8,
    parameter int ID_W   = 4,
    parameter int DEST_W = 1,
    parameter int USER_W = 1
) ();

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [KEEP_W-1:0] tstrb;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    modport src (
        output tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport snk (
        input  tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
        output tready
    );

endinterface

// File: rtl/taxi_stats_ram.sv
// Simple dual-port counter RAM: one write port, one registered read port.
// A read and a write to the same entry on the same edge returns the old contents.
module taxi_stats_ram #(
    parameter int    ADDR_W    = 4,
    parameter int    DATA_W    = 32,
    parameter string RAM_STYLE = "block"
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    if (RAM_STYLE == "distributed") begin : g_dist
        (* ram_style = "distributed" *) logic [DATA_W-1:0] mem [DEPTH];

        // Write port plus registered read of the old contents
        always_ff @(posedge clk) begin
            if (we_i) begin
                mem[waddr_i] <= wdata_i;
            end
            rdata_o <= mem[raddr_i];
        end
    end else begin : g_block
        (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];

        // Write port plus registered read of the old contents
        always_ff @(posedge clk) begin
            if (we_i) begin
                mem[waddr_i] <= wdata_i;
            end
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/taxi_stats_counter.sv
// Per-ID statistics counter bank: accumulates stream increments into RAM-held
// counters through a 3-stage read-modify-write pipeline and serves a read port.
// ID_W and INC_W must equal the tid and tdata widths of the connected stream.
module taxi_stats_counter
    import taxi_stats_pkg::*;
#(
    parameter int    CNT_W     = 32,
    parameter bit    SAT_EN    = 1'b0,
    parameter bit    CLR_ON_RD = 1'b0,
    parameter int    ID_W      = 4,
    parameter int    INC_W     = 8,
    parameter string RAM_STYLE = "block"
) (
    input  logic             clk,
    input  logic             rst_n,
    taxi_axis_if.snk         s_axis_stat,
    input  logic             rd_req,
    input  logic [ID_W-1:0]  rd_addr,
    output logic             rd_ack,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             init_done
);

    state_t            state_q;
    logic [ID_W:0]     initIdx_q;
    logic              initDone_q;

    op_t               s0Op_d;
    logic [ID_W-1:0]   s0Addr_d;
    logic [INC_W-1:0]  s0Inc_d;

    op_t               s1Op_q;
    logic [ID_W-1:0]   s1Addr_q;
    logic [INC_W-1:0]  s1Inc_q;
    logic [CNT_W-1:0]  s1Val_d;

    op_t               s2Op_q;
    logic [ID_W-1:0]   s2Addr_q;
    logic [INC_W-1:0]  s2Inc_q;
    logic [CNT_W-1:0]  s2Old_q;
    logic [CNT_W:0]    s2Sum;
    logic              wrEn_d;
    logic [CNT_W-1:0]  wrData_d;

    logic              ramWe;
    logic [ID_W-1:0]   ramWaddr;
    logic [CNT_W-1:0]  ramWdata;
    logic [CNT_W-1:0]  ramRdata;

    logic              prevWe_q;
    logic [ID_W-1:0]   prevAddr_q;
    logic [CNT_W-1:0]  prevData_q;

    logic [CNT_W-1:0]  rdData_q;
    logic              rdValid_q;
    logic              running;
    logic              unusedSigs;

    assign running            = (state_q == STATE_RUN);
    assign rd_ack             = running & rd_req;
    assign s_axis_stat.tready = running & ~rd_req;
    assign rd_data            = rdData_q;
    assign rd_valid           = rdValid_q;
    assign init_done          = initDone_q;
    assign unusedSigs         = ^{s_axis_stat.tkeep, s_axis_stat.tstrb, s_axis_stat.tlast,
                                  s_axis_stat.tdest, s_axis_stat.tuser};

    // Sweep the RAM to zero after reset, then stay in RUN until the next reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= STATE_INIT;
            initIdx_q  <= '0;
            initDone_q <= 1'b0;
        end else begin
            case (state_q)
                STATE_INIT: begin
                    if (initIdx_q[ID_W]) begin
                        state_q    <= STATE_RUN;
                        initDone_q <= 1'b1;
                    end else begin
                        initIdx_q <= initIdx_q + 1'b1;
                    end
                end
                STATE_RUN: begin
                    state_q <= STATE_RUN;
                end
                default: begin
                    state_q <= STATE_INIT;
                end
            endcase
        end
    end

    // S0: pick the single operation entering the pipeline; reads win, string words are dropped
    always_comb begin
        s0Op_d   = OP_NONE;
        s0Addr_d = rd_addr;
        s0Inc_d  = '0;
        if (rd_ack) begin
            s0Op_d = OP_RD;
        end else if (s_axis_stat.tvalid && s_axis_stat.tready && !s_axis_stat.tuser[0]) begin
            s0Op_d   = OP_UPD;
            s0Addr_d = s_axis_stat.tid;
            s0Inc_d  = s_axis_stat.tdata;
        end
    end

    // S1: replace stale RAM data with the S2 write or the write that landed on the read edge
    always_comb begin
        s1Val_d = ramRdata;
        if (prevWe_q && (prevAddr_q == s1Addr_q)) begin
            s1Val_d = prevData_q;
        end
        if (wrEn_d && (s2Addr_q == s1Addr_q)) begin
            s1Val_d = wrData_d;
        end
    end

    // S2: new counter value, saturating or wrapping, or zero for a clearing read
    always_comb begin
        s2Sum    = {1'b0, s2Old_q} + {{(CNT_W + 1 - INC_W){1'b0}}, s2Inc_q};
        wrEn_d   = 1'b0;
        wrData_d = '0;
        case (s2Op_q)
            OP_UPD: begin
                wrEn_d = 1'b1;
                if (SAT_EN && s2Sum[CNT_W]) begin
                    wrData_d = '1;
                end else begin
                    wrData_d = s2Sum[CNT_W-1:0];
                end
            end
            OP_RD: begin
                wrEn_d = CLR_ON_RD;
            end
            default: begin
                wrEn_d = 1'b0;
            end
        endcase
    end

    // RAM write port is owned by the zeroing sweep in INIT and by S2 in RUN
    always_comb begin
        ramWe    = wrEn_d;
        ramWaddr = s2Addr_q;
        ramWdata = wrData_d;
        if (!running) begin
            ramWe    = ~initIdx_q[ID_W];
            ramWaddr = initIdx_q[ID_W-1:0];
            ramWdata = '0;
        end
    end

    // Advance the pipeline, remember the last write, and register read results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1Op_q     <= OP_NONE;
            s1Addr_q   <= '0;
            s1Inc_q    <= '0;
            s2Op_q     <= OP_NONE;
            s2Addr_q   <= '0;
            s2Inc_q    <= '0;
            s2Old_q    <= '0;
            prevWe_q   <= 1'b0;
            prevAddr_q <= '0;
            prevData_q <= '0;
            rdData_q   <= '0;
            rdValid_q  <= 1'b0;
        end else begin
            s1Op_q     <= s0Op_d;
            s1Addr_q   <= s0Addr_d;
            s1Inc_q    <= s0Inc_d;
            s2Op_q     <= s1Op_q;
            s2Addr_q   <= s1Addr_q;
            s2Inc_q    <= s1Inc_q;
            s2Old_q    <= s1Val_d;
            prevWe_q   <= ramWe;
            prevAddr_q <= ramWaddr;
            prevData_q <= ramWdata;
            rdValid_q  <= (s1Op_q == OP_RD);
            if (s1Op_q == OP_RD) begin
                rdData_q <= s1Val_d;
            end
        end
    end

    taxi_stats_ram #(
        .ADDR_W    (ID_W),
        .DATA_W    (CNT_W),
        .RAM_STYLE (RAM_STYLE)
    ) u_ram (
        .clk     (clk),
        .we_i    (ramWe),
        .waddr_i (ramWaddr),
        .wdata_i (ramWdata),
        .raddr_i (s0Addr_d),
        .rdata_o (ramRdata)
    );

endmodule
